reg_bus_master: RTL and testbench



---
 rtl/reg_bus_pkg.sv | 25 ++
 rtl/reg_bus_phase_timer.sv | 30 +++
 rtl/reg_bus_master.sv | 156 +++++++++++++++
 tb/tb_reg_bus_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the MPU register-bus master.
package reg_bus_pkg;

  localparam int unsigned REG_BUS_ADDR_WIDTH = 8;
  localparam int unsigned REG_BUS_DATA_WIDTH = 16;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } reg_bus_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reg_bus_phase_timer.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
module reg_bus_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns single-cycle commands into setup/strobe/hold bus cycles.
// Optional macro REG_BUS_WRITE_ACK_EN makes writes pulse rsp_valid as well.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = REG_BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = REG_BUS_DATA_WIDTH,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_be,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);

  reg_bus_state_e        state_q, state_d;
  logic                  write_q, write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  bus_en_q, bus_en_d, bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
  logic                  bus_oe_q, bus_oe_d;
  logic [1:0]            bus_be_q, bus_be_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_dout_q, bus_dout_d;
  logic                  timer_load, timer_tc, done_rsp;
  logic [CNT_W-1:0]      timer_val;

  reg_bus_phase_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

`ifdef REG_BUS_WRITE_ACK_EN
  assign done_rsp = 1'b1;
`else
  assign done_rsp = ~write_q;
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        write_d    = cmd_write;
        bus_be_d   = cmd_be;
        bus_addr_d = cmd_addr;
        bus_dout_d = cmd_wdata;
        timer_load = 1'b1;
        if (SETUP_CYCLES != 0) begin
          state_d   = SETUP;
          timer_val = SETUP_LD;
        end else begin
          state_d   = STROBE;
          timer_val = STROBE_LD;
        end
      end
      SETUP: if (timer_tc) begin
        state_d    = STROBE;
        timer_load = 1'b1;
        timer_val  = STROBE_LD;
      end
      STROBE: if (timer_tc) begin
        if (!write_q) rsp_rdata_d = bus_data_in;
        if (HOLD_CYCLES != 0) begin
          state_d    = HOLD;
          timer_load = 1'b1;
          timer_val  = HOLD_LD;
        end else begin
          state_d     = IDLE;
          rsp_valid_d = done_rsp;
        end
      end
      HOLD: if (timer_tc) begin
        state_d     = IDLE;
        rsp_valid_d = done_rsp;
      end
      default: state_d = IDLE;
    endcase
    // Bus pins are registered from the next state so they line up with the phase they belong to.
    bus_en_d = (state_d != IDLE);
    bus_rd_d = (state_d == STROBE) && !write_d;
    bus_wr_d = (state_d == STROBE) && write_d;
    bus_oe_d = (state_d != IDLE) && write_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_en_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_en_q    <= bus_en_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_oe_q    <= bus_oe_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign bus_en       = bus_en_q;
  assign bus_rd       = bus_rd_q;
  assign bus_wr       = bus_wr_q;
  assign bus_data_oe  = bus_oe_q;
  assign bus_be       = bus_be_q;
  assign bus_addr     = bus_addr_q;
  assign bus_data_out = bus_dout_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized bench for reg_bus_master with a register-file responder and a transaction-level model.
module tb_reg_bus_master;
  import reg_bus_pkg::*;

`ifdef REG_BUS_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  localparam int S = 1, T = 2, H = 1, L = S + T + H;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [1:0]  cmd_be = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, bus_en, bus_rd, bus_wr, bus_data_oe;
  logic [15:0] rsp_rdata, bus_data_out, bus_data_in;
  logic [1:0]  bus_be;
  logic [7:0]  bus_addr;

  logic        d2_valid = 1'b0, d2_write = 1'b0;
  logic        d2_ready, d2_rsp, d2_en, d2_rd, d2_wr, d2_oe;
  logic [15:0] d2_rdata, d2_dout, d2_din;
  logic [1:0]  d2_be;
  logic [7:0]  d2_addr;

  logic [15:0] resp_mem [0:255];
  logic [15:0] ref_mem  [0:255];
  logic [15:0] exp_rdata = '0;
  int          n_total = 0, n_bad = 0;

  always #5 clk = ~clk;

  reg_bus_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_en(bus_en), .bus_rd(bus_rd),
    .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );

  reg_bus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(d2_valid), .cmd_ready(d2_ready),
    .cmd_write(d2_write), .cmd_addr(8'h42), .cmd_be(BE_BOTH), .cmd_wdata(16'hC3A5),
    .rsp_valid(d2_rsp), .rsp_rdata(d2_rdata), .bus_en(d2_en), .bus_rd(d2_rd),
    .bus_wr(d2_wr), .bus_be(d2_be), .bus_addr(d2_addr), .bus_data_out(d2_dout),
    .bus_data_oe(d2_oe), .bus_data_in(d2_din)
  );

  // Responder: register file that latches on the falling edge of the write strobe.
  assign bus_data_in = bus_rd ? resp_mem[bus_addr] : 16'h0000;
  assign d2_din      = d2_rd ? 16'h5A3C : 16'h0000;

  always @(negedge bus_wr) begin
    if (bus_en === 1'b1) begin
      if (bus_be[0]) resp_mem[bus_addr][7:0]  <= bus_data_out[7:0];
      if (bus_be[1]) resp_mem[bus_addr][15:8] <= bus_data_out[15:8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command from a negedge; ends on the negedge of the response cycle.
  task automatic do_cmd(input bit w, input logic [7:0] a, input logic [1:0] be,
                        input logic [15:0] d, input bit hold);
    int waited = 0;
    logic [15:0] rd_val;
    bit strobe;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check_eq("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = d;
    rd_val = ref_mem[a];
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      strobe = (k > S) && (k <= S + T);
      check_eq($sformatf("ctl%0d", k),
               {26'd0, bus_en, bus_rd, bus_wr, bus_data_oe, cmd_ready, rsp_valid},
               {26'd0, k <= L, strobe && !w, strobe && w, (k <= L) && w, k == L + 1,
                (k == L + 1) && (!w || ACK)});
      if (k <= L) begin
        check_eq("addr", {24'd0, bus_addr}, {24'd0, a});
        check_eq("be", {30'd0, bus_be}, {30'd0, be});
        if (w) check_eq("dout", {16'd0, bus_data_out}, {16'd0, d});
      end
    end
    if (w) begin
      if (be[0]) ref_mem[a][7:0]  = d[7:0];
      if (be[1]) ref_mem[a][15:8] = d[15:8];
    end else begin
      exp_rdata = rd_val;
    end
    check_eq(w ? "rdata_hold" : "rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 16'h0000;
      ref_mem[i]  = 16'h0000;
    end
    resp_mem[3] = 16'h0123;
    ref_mem[3]  = 16'h0123;

    @(negedge clk);
    check_eq("rst_ctl", {26'd0, bus_en, bus_rd, bus_wr, bus_data_oe, cmd_ready, rsp_valid},
             32'b000010);
    check_eq("rst_addr", {bus_be, 6'd0, bus_addr, bus_data_out}, 32'd0);
    check_eq("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    do_cmd(1'b1, 8'h00, BE_BOTH, 16'h0003, 1'b0);
    do_cmd(1'b0, 8'h00, BE_BOTH, 16'h0000, 1'b0);
    do_cmd(1'b0, 8'h03, BE_BOTH, 16'h0000, 1'b0);
    do_cmd(1'b1, 8'h03, BE_BOTH, 16'h0000, 1'b0);
    do_cmd(1'b1, 8'h03, BE_HI,   16'hABCD, 1'b0);
    do_cmd(1'b0, 8'h03, BE_BOTH, 16'h0000, 1'b0);
    check_eq("be_hi_read", {16'd0, rsp_rdata}, 32'h0000AB00);
    do_cmd(1'b1, 8'h04, 2'b00,   16'hFFFF, 1'b0);
    do_cmd(1'b0, 8'h03, BE_BOTH, 16'h0000, 1'b1);
    do_cmd(1'b0, 8'h00, BE_BOTH, 16'h0000, 1'b0);
    do_cmd(1'b0, 8'h04, BE_LO,   16'h0000, 1'b0);

    // Reset in the middle of a write strobe
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_be = BE_BOTH; cmd_wdata = 16'h7777;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_wr", {31'd0, bus_wr}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_ctl", {26'd0, bus_en, bus_rd, bus_wr, bus_data_oe, cmd_ready, rsp_valid},
             32'b000010);
    exp_rdata = '0;
    check_eq("mid_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    end
    do_cmd(1'b1, 8'h05, BE_BOTH, 16'h1234, 1'b0);
    do_cmd(1'b0, 8'h05, BE_BOTH, 16'h0000, 1'b0);

    // Randomized traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      int gap;
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             16'($urandom), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      if (gap > 0) cmd_valid = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
    for (int a = 0; a < 8; a++) do_cmd(1'b0, 8'(a), BE_BOTH, 16'h0000, 1'b0);
    cmd_valid = 1'b0;

    // Minimal timing instance: no setup, one strobe cycle, no hold
    d2_valid = 1'b1; d2_write = 1'b1;
    @(posedge clk);
    #1 d2_valid = 1'b0;
    @(negedge clk);
    check_eq("d2_wr_c1", {26'd0, d2_en, d2_rd, d2_wr, d2_oe, d2_ready, d2_rsp}, 32'b101100);
    check_eq("d2_wr_bus", {d2_be, 6'd0, d2_addr, d2_dout}, {2'b11, 6'd0, 8'h42, 16'hC3A5});
    @(negedge clk);
    check_eq("d2_wr_c2", {26'd0, d2_en, d2_rd, d2_wr, d2_oe, d2_ready, d2_rsp},
             {26'd0, 5'b00001, ACK});
    d2_valid = 1'b1; d2_write = 1'b0;
    @(posedge clk);
    #1 d2_valid = 1'b0;
    @(negedge clk);
    check_eq("d2_rd_c1", {26'd0, d2_en, d2_rd, d2_wr, d2_oe, d2_ready, d2_rsp}, 32'b110000);
    @(negedge clk);
    check_eq("d2_rd_c2", {26'd0, d2_en, d2_rd, d2_wr, d2_oe, d2_ready, d2_rsp}, 32'b000011);
    check_eq("d2_rdata", {16'd0, d2_rdata}, 32'h00005A3C);
    @(negedge clk);
    check_eq("d2_rsp_once", {31'd0, d2_rsp}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
